xtalk_encoder: RTL and testbench
================================

XTALK_ENCODER -- requirements
Module: xtalk_encoder

Interface
REQ-001 SHALL have parameter W, default 31, payload width; the output flit is W+1 bits.
REQ-002 SHALL have parameter CW, default 5, width of the pair counters (>= clog2(W)).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port enc_en  input  1  encoding enable; 0 = bypass (flag forced 0).
REQ-006 SHALL have port in_valid  input  1  payload offered.
REQ-007 SHALL have port in_data  input  W  payload.
REQ-008 SHALL have port in_ready  output  1  payload accepted when in_valid && in_ready.
REQ-009 SHALL have port out_valid  output  1  flit held on out_flit.
REQ-010 SHALL have port out_flit  output  W+1  bit W = invert flag; bits W-1:0 = encoded payload.
REQ-011 SHALL have port out_ready  input  1  downstream consumes flit when out_valid && out_ready.

Function
REQ-012 SHALL hold bus_prev[W-1:0], the encoded payload of the most recently loaded flit.
REQ-013 SHALL, for each adjacent pair i = 0..W-2, compare bus_prev bits {i+1,i} with in_data bits {i+1,i}:
- opp_i = 1 when one bit rises 0->1 and the other falls 1->0.
- same_i = 1 when both bits rise or both bits fall.
REQ-014 SHALL form C2 = sum of opp_i and C4 = sum of same_i, each CW bits, combinationally.
REQ-015 SHALL set inv = enc_en && (C2 > C4); a tie SHALL give inv = 0.
REQ-016 SHALL form the flit as {inv, in_data ^ {W{inv}}}.
REQ-017 SHALL use an output register with latency 1: a flit accepted on edge N appears on out_flit/out_valid after edge N.
REQ-018 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-019 On accept, SHALL load out_flit, set out_valid = 1, and set bus_prev = the encoded payload in the same edge.
REQ-020 On consume with no accept, SHALL clear out_valid; out_flit and bus_prev SHALL be held.
REQ-021 On simultaneous consume and accept, SHALL replace the flit with no bubble, giving full throughput.
REQ-022 While out_valid && !out_ready, out_flit SHALL be stable and in_ready SHALL be 0.
REQ-023 SHALL ignore in_data when in_valid = 0; no state SHALL change.

Reset
REQ-024 When rst_n = 0 at an edge, out_valid SHALL = 0, out_flit SHALL = 0 and bus_prev SHALL = 0.
REQ-025 A reset asserted mid-transfer SHALL discard the held flit; the first post-reset flit SHALL be encoded against bus_prev = 0.
REQ-026 in_ready SHALL = 1 on the first cycle after reset deasserts.

Configuration
REQ-027 With XTALK_STATS_EN defined, SHALL add output inv_cnt (16 bits).
- inv_cnt increments on each accepted flit with inv = 1.
- inv_cnt saturates at 0xFFFF.
- inv_cnt resets to 0.
REQ-028 Without XTALK_STATS_EN, inv_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Invert case, W=31, out_ready=1, enc_en=1:
- send 0x55555555 -> out_flit 0x55555555 (flag 0, since C2=0, C4=0).
- then send 0x2AAAAAAA -> C2=30, out_flit 0xD5555555.
REQ-030 No-invert case: after reset, send 0x7FFFFFFF -> C4=30, C2=0, out_flit 0x7FFFFFFF.
REQ-031 Bypass case: enc_en=0, repeat REQ-029 -> second flit is 0x2AAAAAAA, flag 0.
REQ-032 Backpressure case: out_ready=0 with two payloads offered:
- first flit is held stable;
- in_ready=0 while it is held;
- raising out_ready passes both flits in order, no loss or duplication.
REQ-033 Reset case: assert rst_n=0 while a flit is stalled:
- out_valid drops on the next edge;
- then send 0x2AAAAAAA -> out_flit 0x2AAAAAAA, because the encoding is against bus_prev = 0.
REQ-034 Stats case, XTALK_STATS_EN defined: run REQ-029 three times -> inv_cnt = 3; preload near saturation -> inv_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/xtalk_encoder.sv
// Crosstalk-avoiding bus-invert encoder: one output register stage with a valid/ready handshake.
// Optional inversion counter output is enabled with `define XTALK_STATS_EN.
module xtalk_encoder #(
   parameter int unsigned W  = 31,
   parameter int unsigned CW = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enc_en,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W:0]   out_flit,
   input  logic         out_ready
`ifdef XTALK_STATS_EN
   ,
   output logic [15:0]  inv_cnt
`endif
);

   logic [W-1:0]  bus_prev;
   logic [CW-1:0] c2;
   logic [CW-1:0] c4;
   logic          inv;
   logic [W-1:0]  enc;
   logic          accept;

   // A pair toggling both wires counts as opposing when the new values differ, same-direction otherwise
   always_comb begin
      c2 = '0;
      c4 = '0;
      for (int i = 0; i < int'(W) - 1; i++) begin
         c2 = c2 + CW'((bus_prev[i] ^ in_data[i]) & (bus_prev[i+1] ^ in_data[i+1])
                       & (in_data[i] ^ in_data[i+1]));
         c4 = c4 + CW'((bus_prev[i] ^ in_data[i]) & (bus_prev[i+1] ^ in_data[i+1])
                       & ~(in_data[i] ^ in_data[i+1]));
      end
   end

   assign inv      = enc_en && (c2 > c4);
   assign enc      = in_data ^ {W{inv}};
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Output stage; bus_prev tracks what was actually driven onto the wires
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_flit  <= '0;
         bus_prev  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_flit  <= {inv, enc};
         bus_prev  <= enc;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef XTALK_STATS_EN
   // Saturating count of inverted flits
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inv_cnt <= '0;
      end else if (accept && inv && (inv_cnt != 16'hFFFF)) begin
         inv_cnt <= inv_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_xtalk_encoder.sv
// Randomized and directed bench for xtalk_encoder against a transition-counting reference model.
// Define XTALK_STATS_EN to also exercise the inversion counter.
module tb_xtalk_encoder;
   localparam int unsigned W  = 31;
   localparam int unsigned CW = 5;

   logic         clk;
   logic         rst_n;
   logic         enc_en;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         out_valid;
   logic [W:0]   out_flit;
   logic         out_ready;
`ifdef XTALK_STATS_EN
   logic [15:0]  inv_cnt;
   int           m_cnt;
`endif

   xtalk_encoder #(.W(W), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enc_en    (enc_en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_flit  (out_flit),
      .out_ready (out_ready)
`ifdef XTALK_STATS_EN
      ,
      .inv_cnt   (inv_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic         m_valid;
   logic [W:0]   m_flit;
   logic [W-1:0] m_prev;

   localparam logic [W-1:0] P55 = 31'h5555_5555;
   localparam logic [W-1:0] P2A = 31'h2AAA_AAAA;
   localparam logic [W-1:0] P7F = 31'h7FFF_FFFF;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Per-wire movement is +1 (rise), -1 (fall) or 0; a pair product of -1 is opposing, +1 same-direction
   function automatic logic [W:0] ref_encode(input logic [W-1:0] prev, input logic [W-1:0] data,
                                             input logic en);
      int opp = 0;
      int same = 0;
      logic flag;
      for (int i = 0; i < int'(W) - 1; i++) begin
         int d0 = int'(data[i]) - int'(prev[i]);
         int d1 = int'(data[i+1]) - int'(prev[i+1]);
         if (d0 * d1 == -1) opp++;
         else if (d0 * d1 == 1) same++;
      end
      flag = en && (opp > same);
      return {flag, flag ? ~data : data};
   endfunction

   // One clock: drive, check pre-edge outputs against the model, advance the model, cross the edge
   task automatic step(input logic v, input logic [W-1:0] d, input logic ordy, input logic en,
                       input logic rst);
      logic acc;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      enc_en    = en;
      rst_n     = rst;
      #1;
      check("in_ready", 64'(in_ready), 64'(!m_valid || ordy));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) check("out_flit", 64'(out_flit), 64'(m_flit));
`ifdef XTALK_STATS_EN
      check("inv_cnt", 64'(inv_cnt), 64'(m_cnt));
`endif
      acc = v && (!m_valid || ordy);
      if (!rst) begin
         m_valid = 1'b0;
         m_flit  = '0;
         m_prev  = '0;
`ifdef XTALK_STATS_EN
         m_cnt   = 0;
`endif
      end else if (acc) begin
         m_flit  = ref_encode(m_prev, d, en);
         m_valid = 1'b1;
         m_prev  = m_flit[W-1:0];
`ifdef XTALK_STATS_EN
         if (m_flit[W] && m_cnt < 65535) m_cnt++;
`endif
      end else if (m_valid && ordy) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      enc_en    = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      m_valid   = 1'b0;
      m_flit    = '0;
      m_prev    = '0;
`ifdef XTALK_STATS_EN
      m_cnt     = 0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_flit", 64'(out_flit), 64'd0);
      rst_n = 1'b1;
      #1;
      check("rst_ready", 64'(in_ready), 64'd1);

      // Opposing transitions on every pair force inversion
      step(1'b1, P55, 1'b1, 1'b1, 1'b1);
      check("inv_first", 64'(out_flit), 64'h5555_5555);
      step(1'b1, P2A, 1'b1, 1'b1, 1'b1);
      check("inv_second", 64'(out_flit), 64'hD555_5555);
      step(1'b0, '0, 1'b1, 1'b1, 1'b1);

      // All wires rising together never inverts
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      step(1'b1, P7F, 1'b1, 1'b1, 1'b1);
      check("noinv", 64'(out_flit), 64'h7FFF_FFFF);

      // Bypass
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b1, P55, 1'b1, 1'b0, 1'b1);
      step(1'b1, P2A, 1'b1, 1'b0, 1'b1);
      check("bypass", 64'(out_flit), 64'h2AAA_AAAA);
      step(1'b0, '0, 1'b1, 1'b1, 1'b1);

      // Backpressure: first flit held, second waits, then both drain in order
      step(1'b1, P7F, 1'b0, 1'b1, 1'b1);
      check("bp_first", 64'(out_flit), 64'(ref_encode(P2A, P7F, 1'b1)));
      step(1'b1, P55, 1'b0, 1'b1, 1'b1);
      check("bp_ready_low", 64'(in_ready), 64'd0);
      check("bp_stable", 64'(out_flit), 64'(ref_encode(P2A, P7F, 1'b1)));
      step(1'b1, P55, 1'b1, 1'b1, 1'b1);
      check("bp_second", 64'(out_flit),
            64'(ref_encode(ref_encode(P2A, P7F, 1'b1), P55, 1'b1)));
      step(1'b0, '0, 1'b1, 1'b1, 1'b1);
      check("bp_drained", 64'(out_valid), 64'd0);

      // Reset during a stall discards the flit and clears the history
      step(1'b1, P55, 1'b0, 1'b1, 1'b1);
      step(1'b1, P7F, 1'b0, 1'b1, 1'b0);
      check("rst_drop", 64'(out_valid), 64'd0);
      step(1'b1, P2A, 1'b1, 1'b1, 1'b1);
      check("rst_prev0", 64'(out_flit), 64'h2AAA_AAAA);
      step(1'b0, '0, 1'b1, 1'b1, 1'b1);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         logic [W-1:0] d;
         logic         v;
         logic         r;
         logic         e;
         logic         rs;
         d  = W'($urandom);
         if ($urandom_range(0, 3) == 0) d = m_prev ^ W'($urandom & 32'h0F0F_0F0F);
         if ($urandom_range(0, 3) == 0) d = ~m_prev;
         v  = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 2) != 0);
         e  = ($urandom_range(0, 5) != 0);
         rs = ($urandom_range(0, 49) != 0);
         step(v, d, r, e, rs);
      end

`ifdef XTALK_STATS_EN
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      for (int n = 0; n < 3; n++) begin
         step(1'b1, P55, 1'b1, 1'b1, 1'b1);
         step(1'b1, P2A, 1'b1, 1'b1, 1'b1);
      end
      check("cnt_three", 64'(inv_cnt), 64'd3);
      for (int n = 0; n < 65540; n++) step(1'b1, P2A, 1'b1, 1'b1, 1'b1);
      check("cnt_sat", 64'(inv_cnt), 64'hFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
